// File: rtl/tt_prog_counter.sv
// Programmable counter: prescaled ticks, up/down, load, wrap/saturate/one-shot modes.
// Optional capture register enabled by defining COUNTER_CAPTURE_EN.
module tt_prog_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PS_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [PS_W-1:0]  prescale,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             cap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cmp_match,
  output logic             done,
  output logic [WIDTH-1:0] cap_val
);

  localparam logic [WIDTH-1:0] MAX       = '1;
  localparam logic [1:0]       MODE_SAT  = 2'b01;
  localparam logic [1:0]       MODE_ONE  = 2'b10;

  logic [PS_W-1:0] ps_cnt;
  logic            tick_c;
  logic            at_bound_c;

  assign tick_c     = en & (ps_cnt == prescale);
  assign at_bound_c = dir ? (count == '0) : (count == MAX);
  assign cmp_match  = (count == cmp_val);

  // Prescaler; a prescale lowered below ps_cnt is reached again after a natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (load) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= tick_c ? '0 : ps_cnt + PS_W'(1);
    end
  end

  // Count, terminal-count pulse and sticky one-shot done; load overrides any tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (tick_c && !done) begin
        if (!at_bound_c) begin
          count <= dir ? count - WIDTH'(1) : count + WIDTH'(1);
        end else begin
          case (mode)
            MODE_SAT: tc <= 1'b1;
            MODE_ONE: begin
              done <= 1'b1;
              tc   <= 1'b1;
            end
            default: begin
              count <= dir ? MAX : '0;
              tc    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

`ifdef COUNTER_CAPTURE_EN
  // Captures the count as it stood before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_val <= '0;
    end else if (cap) begin
      cap_val <= count;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = cap;
  assign cap_val    = '0;
`endif

endmodule

// File: tb/tb_tt_prog_counter.sv
// Scoreboard bench for tt_prog_counter (WIDTH=8, PS_W=4); honours COUNTER_CAPTURE_EN.
module tb_tt_prog_counter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PS_W  = 4;
  localparam int unsigned MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [PS_W-1:0]  prescale;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  logic             cap;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             cmp_match;
  logic             done;
  logic [WIDTH-1:0] cap_val;

  tt_prog_counter #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
    .prescale(prescale), .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .cap(cap), .count(count), .tc(tc), .cmp_match(cmp_match), .done(done),
    .cap_val(cap_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tcv;
    int dn;
    int cm;
    int cv;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference state
  int m_count, m_ps, m_done, m_tc, m_cap;

  task automatic check(input string tag, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
  endtask

  task automatic model_reset();
    m_count = 0; m_ps = 0; m_done = 0; m_tc = 0; m_cap = 0;
  endtask

  // Advance the reference by one edge using the currently driven inputs.
  task automatic model_edge();
    bit tick, bound;
    exp_t e;
    tick = en && (m_ps == int'(prescale));
`ifdef COUNTER_CAPTURE_EN
    if (cap) m_cap = m_count;
`endif
    if (load) begin
      m_count = int'(load_val); m_ps = 0; m_done = 0; m_tc = 0;
    end else begin
      if (en) m_ps = tick ? 0 : (m_ps + 1) % (1 << PS_W);
      m_tc = 0;
      if (tick && m_done == 0) begin
        bound = dir ? (m_count == 0) : (m_count == int'(MAXV));
        if (!bound) m_count = dir ? m_count - 1 : m_count + 1;
        else if (mode == 2'b01) m_tc = 1;
        else if (mode == 2'b10) begin m_tc = 1; m_done = 1; end
        else begin m_count = dir ? int'(MAXV) : 0; m_tc = 1; end
      end
    end
    e.cnt = m_count; e.tcv = m_tc; e.dn = m_done;
    e.cm = (m_count == int'(cmp_val)) ? 1 : 0; e.cv = m_cap;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("count", int'(count), e.cnt);
      check("tc", int'(tc), e.tcv);
      check("done", int'(done), e.dn);
      check("cmp_match", int'(cmp_match), e.cm);
      check("cap_val", int'(cap_val), e.cv);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; dir = 1'b0; mode = 2'b00; prescale = '0;
    load = 1'b0; load_val = '0; cmp_val = 8'h07; cap = 1'b0;
    model_reset();
    #12;
    check("rst_count", int'(count), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_done", int'(done), 0);
    check("rst_cap", int'(cap_val), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free run through a full wrap
    run(255);
    check("free_255", int'(count), 255);
    check("free_tc_pre", int'(tc), 0);
    run(1);
    check("wrap_cnt", int'(count), 0);
    check("wrap_tc", int'(tc), 1);
    run(1);
    check("wrap_tc_clr", int'(tc), 0);

    // Prescale 3 with an enable gap
    load = 1'b1; load_val = 8'h00; run(1); load = 1'b0;
    prescale = 4'd3;
    run(6);
    en = 1'b0; run(5);
    en = 1'b1; run(6);
    check("ps_cnt3", int'(count), 3);

    // Saturating down count
    prescale = '0;
    load = 1'b1; load_val = 8'h05; run(1); load = 1'b0;
    dir = 1'b1; mode = 2'b01;
    run(8);
    check("sat_cnt", int'(count), 0);
    check("sat_tc", int'(tc), 1);

    // One-shot up count
    load = 1'b1; load_val = 8'hFD; run(1); load = 1'b0;
    dir = 1'b0; mode = 2'b10;
    run(3);
    check("os_done", int'(done), 1);
    check("os_tc", int'(tc), 1);
    run(3);
    check("os_hold", int'(count), 8'hFF);
    dir = 1'b1; mode = 2'b00; run(2);
    check("os_sticky", int'(done), 1);
    dir = 1'b0;
    load = 1'b1; load_val = 8'h10; run(1); load = 1'b0;
    check("os_reload_done", int'(done), 0);
    run(1);
    check("os_resume", int'(count), 8'h11);

    // Prescale lowered below current phase
    prescale = 4'd5; run(3);
    prescale = 4'd1; run(20);

    // Capture, alone and together with load
    prescale = '0; mode = 2'b00;
    load = 1'b1; load_val = 8'h28; run(1); load = 1'b0;
    run(2);
    cap = 1'b1; run(1); cap = 1'b0;
`ifdef COUNTER_CAPTURE_EN
    check("cap_2a", int'(cap_val), 8'h2A);
`else
    check("cap_off", int'(cap_val), 0);
`endif
    run(1);
    cap = 1'b1; load = 1'b1; load_val = 8'h99; run(1);
    cap = 1'b0; load = 1'b0;
    run(2);

    // Asynchronous reset between edges
    run(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", int'(count), 0);
    check("arst_tc", int'(tc), 0);
    check("arst_done", int'(done), 0);
    check("arst_cap", int'(cap_val), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(9);
    check("post_rst", int'(count), 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
